// File: rtl/cmd_timing_scheduler.sv
// Single-entry issue stage that holds each SoftMC DDR instruction until the
// per-bank and global DDR timing constraints allow it to reach the DFI decoder.
module cmd_timing_scheduler #(
  parameter int unsigned BANK_WIDTH = 3,
  parameter int unsigned CS_WIDTH   = 1,
  parameter int unsigned ROW_OFFSET = 15,
  parameter int unsigned WE_OFFSET  = 18,
  parameter int unsigned CAS_OFFSET = 19,
  parameter int unsigned RAS_OFFSET = 20,
  parameter int unsigned CS_OFFSET  = 21,
  parameter int unsigned TW         = 6,
  parameter int unsigned T_RCD      = 4,
  parameter int unsigned T_RP       = 4,
  parameter int unsigned T_RAS      = 10,
  parameter int unsigned T_RTP      = 2,
  parameter int unsigned T_WTP      = 8,
  parameter int unsigned T_RRD      = 2,
  parameter int unsigned T_RFC      = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic        dec_en,
  output logic [31:0] dec_instr,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] stall_cycles
);

  localparam int unsigned NB = 1 << BANK_WIDTH;
  localparam logic [TW-1:0] RCD_LD = TW'(T_RCD - 1);
  localparam logic [TW-1:0] RP_LD  = TW'(T_RP - 1);
  localparam logic [TW-1:0] RAS_LD = TW'(T_RAS - 1);
  localparam logic [TW-1:0] RTP_LD = TW'(T_RTP - 1);
  localparam logic [TW-1:0] WTP_LD = TW'(T_WTP - 1);
  localparam logic [TW-1:0] RRD_LD = TW'(T_RRD - 1);
  localparam logic [TW-1:0] RFC_LD = TW'(T_RFC - 1);

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_OTHER
  } cmd_e;

  logic                  hold_valid_q, hold_valid_d;
  logic [31:0]           hold_q, hold_d;
  logic                  dec_en_q, dec_en_d;
  logic [31:0]           dec_instr_q, dec_instr_d;
  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [15:0]           stall_q, stall_d;
  logic [NB-1:0]         open_q, open_d;
  logic [TW-1:0]         act_cnt_q [NB];
  logic [TW-1:0]         act_cnt_d [NB];
  logic [TW-1:0]         rcd_cnt_q [NB];
  logic [TW-1:0]         rcd_cnt_d [NB];
  logic [TW-1:0]         pre_cnt_q [NB];
  logic [TW-1:0]         pre_cnt_d [NB];
  logic [TW-1:0]         rrd_cnt_q, rrd_cnt_d;
  logic [TW-1:0]         rfc_cnt_q, rfc_cnt_d;

  logic [CS_WIDTH-1:0]   cs_n;
  logic [2:0]            rcw;
  logic [BANK_WIDTH-1:0] bank;
  cmd_e                  cmd;
  logic                  all_act_zero;
  logic                  cond_ok;
  logic                  issue;
  logic                  err_hit;
  logic [1:0]            err_hit_code;

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - TW'(1);
  endfunction

  function automatic logic [TW-1:0] max_cnt(input logic [TW-1:0] a, input logic [TW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign cs_n = hold_q[CS_OFFSET +: CS_WIDTH];
  assign rcw  = {hold_q[RAS_OFFSET], hold_q[CAS_OFFSET], hold_q[WE_OFFSET]};
  assign bank = hold_q[ROW_OFFSET +: BANK_WIDTH];

  // Command decode of the held instruction (deselect or H H H is a NOP)
  always_comb begin
    cmd = CMD_OTHER;
    if ((&cs_n) || (rcw == 3'b111)) begin
      cmd = CMD_NOP;
    end else begin
      case (rcw)
        3'b011:  cmd = CMD_ACT;
        3'b101:  cmd = CMD_RD;
        3'b100:  cmd = CMD_WR;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_REF;
        default: cmd = CMD_OTHER;
      endcase
    end
  end

  always_comb begin
    all_act_zero = 1'b1;
    for (int i = 0; i < int'(NB); i++) begin
      if (act_cnt_q[i] != '0) all_act_zero = 1'b0;
    end
  end

  // Timing gate: every non-NOP command also waits for the refresh window
  always_comb begin
    cond_ok = 1'b0;
    case (cmd)
      CMD_NOP:       cond_ok = 1'b1;
      CMD_ACT:       cond_ok = (act_cnt_q[bank] == '0) && (rrd_cnt_q == '0) && (rfc_cnt_q == '0);
      CMD_RD, CMD_WR: cond_ok = (rcd_cnt_q[bank] == '0) && (rfc_cnt_q == '0);
      CMD_PRE:       cond_ok = (pre_cnt_q[bank] == '0) && (rfc_cnt_q == '0);
      CMD_REF:       cond_ok = all_act_zero && (rfc_cnt_q == '0);
      default:       cond_ok = (rfc_cnt_q == '0);
    endcase
  end

  assign issue    = hold_valid_q && cond_ok;
  assign in_ready = !hold_valid_q || issue;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    dec_en_d     = issue;
    dec_instr_d  = hold_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    stall_d      = stall_q;
    open_d       = open_q;
    rrd_cnt_d    = dec_sat(rrd_cnt_q);
    rfc_cnt_d    = dec_sat(rfc_cnt_q);
    err_hit      = 1'b0;
    err_hit_code = 2'd0;
    for (int i = 0; i < int'(NB); i++) begin
      act_cnt_d[i] = dec_sat(act_cnt_q[i]);
      rcd_cnt_d[i] = dec_sat(rcd_cnt_q[i]);
      pre_cnt_d[i] = dec_sat(pre_cnt_q[i]);
    end

    if (in_valid && in_ready) begin
      hold_valid_d = 1'b1;
      hold_d       = in_instr;
    end else if (issue) begin
      hold_valid_d = 1'b0;
    end

    if (hold_valid_q && !issue && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end

    // Counter loads and bank state on issue; violations are flagged but still issue
    if (issue) begin
      case (cmd)
        CMD_ACT: begin
          rcd_cnt_d[bank] = RCD_LD;
          pre_cnt_d[bank] = max_cnt(pre_cnt_q[bank], RAS_LD);
          rrd_cnt_d       = RRD_LD;
          open_d[bank]    = 1'b1;
          if (open_q[bank]) begin
            err_hit      = 1'b1;
            err_hit_code = 2'd1;
          end
        end
        CMD_RD, CMD_WR: begin
          pre_cnt_d[bank] = max_cnt(dec_sat(pre_cnt_q[bank]), (cmd == CMD_RD) ? RTP_LD : WTP_LD);
          if (!open_q[bank]) begin
            err_hit      = 1'b1;
            err_hit_code = 2'd2;
          end
        end
        CMD_PRE: begin
          act_cnt_d[bank] = RP_LD;
          open_d[bank]    = 1'b0;
        end
        CMD_REF: begin
          rfc_cnt_d = RFC_LD;
          if (|open_q) begin
            err_hit      = 1'b1;
            err_hit_code = 2'd3;
          end
        end
        default: ;
      endcase
    end

    if (err_hit) begin
      err_d = 1'b1;
      if (!err_q) err_code_d = err_hit_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      dec_en_q     <= 1'b0;
      dec_instr_q  <= '0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
      stall_q      <= '0;
      open_q       <= '0;
      act_cnt_q    <= '{default: '0};
      rcd_cnt_q    <= '{default: '0};
      pre_cnt_q    <= '{default: '0};
      rrd_cnt_q    <= '0;
      rfc_cnt_q    <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      dec_en_q     <= dec_en_d;
      dec_instr_q  <= dec_instr_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      stall_q      <= stall_d;
      open_q       <= open_d;
      act_cnt_q    <= act_cnt_d;
      rcd_cnt_q    <= rcd_cnt_d;
      pre_cnt_q    <= pre_cnt_d;
      rrd_cnt_q    <= rrd_cnt_d;
      rfc_cnt_q    <= rfc_cnt_d;
    end
  end

  assign dec_en       = dec_en_q;
  assign dec_instr    = dec_instr_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_cmd_timing_scheduler.sv
// Scoreboard bench: stimulus pushes the expected decoder word and issue cycle,
// a negedge monitor pops and compares on every dec_en.
module tb_cmd_timing_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic        dec_en;
  logic [31:0] dec_instr;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] instr;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  localparam logic [2:0] ACT = 3'b011, RD = 3'b101, WR = 3'b100,
                         PRE = 3'b010, REF = 3'b001, NOP = 3'b111;

  cmd_timing_scheduler dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .dec_en(dec_en), .dec_instr(dec_instr),
    .err(err), .err_code(err_code), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every dec_en must match the oldest expected entry, instruction and cycle
  always @(negedge clk) begin
    if (dec_en) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_dec_en: instr=%h at cycle %0d, required no issue", dec_instr, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (dec_instr !== mon_e.instr || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL dec_issue: got instr=%h cycle=%0d, required instr=%h cycle=%0d",
                   dec_instr, cyc, mon_e.instr, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [2:0] rcw, input logic [2:0] bank, input logic [7:0] tag);
    logic [31:0] v;
    v        = '0;
    v[20:18] = rcw;
    v[17:15] = bank;
    v[7:0]   = tag;
    return v;
  endfunction

  function automatic void push(input logic [31:0] ins, input int c);
    exp_t e;
    e.instr = ins;
    e.cyc   = c;
    sb.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Present one instruction, return the cycle in which it was accepted
  task automatic send(input logic [31:0] ins, output int acc);
    int n;
    bit done;
    n = 0;
    done = 0;
    acc = -1;
    in_valid = 1'b1;
    in_instr = ins;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc;
        done = 1;
      end else if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: instr=%h never accepted, required acceptance", ins);
        done = 1;
      end
      n++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: %0d expected issues missing, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    int base, acc;
    logic [31:0] x;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_dec_en", 32'(dec_en), 32'd0);
    chk("rst_dec_instr", dec_instr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // ACT b2 then RD b2: tRCD stall of 3 cycles
    do_reset();
    x = mk(ACT, 3'd2, 8'h01); send(x, base); push(x, base + 2);
    x = mk(RD, 3'd2, 8'h02);  send(x, acc);  push(x, base + 6);
    @(negedge clk);
    chk("rcd_in_ready_low", 32'(in_ready), 32'd0);
    wait_empty();
    chk("rcd_stall_cycles", 32'(stall_cycles), 32'd3);
    chk("rcd_err", 32'(err), 32'd0);

    // ACT b0, ACT b1: tRRD spacing
    do_reset();
    x = mk(ACT, 3'd0, 8'h03); send(x, base); push(x, base + 2);
    x = mk(ACT, 3'd1, 8'h04); send(x, acc);  push(x, base + 4);
    wait_empty();
    chk("rrd_err", 32'(err), 32'd0);

    // ACT, WR, PRE, ACT on b3: PRE bound by write recovery, ACT by tRP
    do_reset();
    x = mk(ACT, 3'd3, 8'h05); send(x, base); push(x, base + 2);
    x = mk(WR, 3'd3, 8'h06);  send(x, acc);  push(x, base + 6);
    x = mk(PRE, 3'd3, 8'h07); send(x, acc);  push(x, base + 14);
    x = mk(ACT, 3'd3, 8'h08); send(x, acc);  push(x, base + 18);
    wait_empty();
    chk("bank_cycle_err", 32'(err), 32'd0);

    // REF, NOP, ACT b0: NOP unconstrained, ACT waits tRFC
    do_reset();
    x = mk(REF, 3'd0, 8'h09); send(x, base); push(x, base + 2);
    x = mk(NOP, 3'd0, 8'h0A); send(x, acc);  push(x, base + 3);
    x = mk(ACT, 3'd0, 8'h0B); send(x, acc);  push(x, base + 42);
    wait_empty();
    chk("rfc_err", 32'(err), 32'd0);

    // RD to closed bank, then a double ACT: first error code sticks
    do_reset();
    x = mk(RD, 3'd5, 8'h0C); send(x, base); push(x, base + 2);
    wait_empty();
    chk("closed_rd_err", 32'(err), 32'd1);
    chk("closed_rd_code", 32'(err_code), 32'd2);
    x = mk(ACT, 3'd5, 8'h0D); send(x, base); push(x, base + 2);
    x = mk(ACT, 3'd5, 8'h0E); send(x, acc);  push(x, base + 4);
    wait_empty();
    chk("sticky_err", 32'(err), 32'd1);
    chk("sticky_code", 32'(err_code), 32'd2);

    // REF with a bank open
    do_reset();
    x = mk(ACT, 3'd1, 8'h0F); send(x, base); push(x, base + 2);
    x = mk(REF, 3'd0, 8'h10); send(x, acc);  push(x, base + 3);
    wait_empty();
    chk("ref_open_err", 32'(err), 32'd1);
    chk("ref_open_code", 32'(err_code), 32'd3);

    // 20 back-to-back NOPs, then reset mid-stream
    do_reset();
    base = -1;
    for (int i = 0; i < 20; i++) begin
      x = mk(NOP, 3'(i), 8'(8'h20 + i));
      send(x, acc);
      if (i == 0) base = acc;
      push(x, base + i + 2);
    end
    chk("nop_stall", 32'(stall_cycles), 32'd0);
    in_valid = 1'b1;
    in_instr = mk(NOP, 3'd0, 8'h99);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_dec_en", 32'(dec_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dropped_instr", 32'(dec_en), 32'd0);
    end
    chk("mid_rst_stall", 32'(stall_cycles), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_timing_scheduler.md
Name: cmd_timing_scheduler

Overview:
- Sits between the host instruction FIFO and the DFI instruction decoder.
- Accepts 32-bit SoftMC DDR instructions over a valid/ready handshake and holds each one in a single-entry issue register.
- Releases the instruction to the decoder (decoder enable plus instruction) only once all per-bank and global DDR timing constraints are met.
- Tracks bank open/closed state, flags protocol errors, and counts stall cycles for host readback.

Parameters:
- BANK_WIDTH, 3, bank address bits; number of banks NB = 2**BANK_WIDTH.
- CS_WIDTH, 1, chip-select field width.
- ROW_OFFSET, 15, bit position of the bank field LSB in the instruction.
- WE_OFFSET, 18, bit position of we_n.
- CAS_OFFSET, 19, bit position of cas_n.
- RAS_OFFSET, 20, bit position of ras_n.
- CS_OFFSET, 21, bit position of cs_n LSB.
- TW, 6, timing counter width.
- T_RCD, 4, ACT to RD/WR, same bank (cycles).
- T_RP, 4, PRE to ACT, same bank.
- T_RAS, 10, ACT to PRE, same bank.
- T_RTP, 2, RD to PRE, same bank.
- T_WTP, 8, WR to PRE, same bank (write latency + burst + tWR, lumped).
- T_RRD, 2, ACT to ACT, any bank.
- T_RFC, 40, REF to any non-NOP command.

Ports:
- clk  in  1  controller clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction available.
- in_instr  in  32  SoftMC instruction.
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready.
- dec_en  out  1  drives the decoder enable for one cycle per issued instruction.
- dec_instr  out  32  instruction to decoder; valid when dec_en = 1.
- err  out  1  sticky protocol-error flag.
- err_code  out  2  first error: 1 = ACT to open bank, 2 = RD/WR to closed bank, 3 = REF with a bank open.
- stall_cycles  out  16  saturating count of cycles in which the hold register is full and not issued.

Behaviour:
- Reset (sync, rst = 1) clears:
  - hold_valid, dec_en, err, err_code, stall_cycles to 0; dec_instr to 0;
  - all banks to closed; all timing counters to 0.
- Reset mid-operation discards any held instruction.
- Decode of the held instruction (r = ras_n, c = cas_n, w = we_n):
  - ACT = L H H; RD = H L H; WR = H L L; PRE = L H L; REF = L L H.
  - All cs_n bits high, or r/c/w = H H H, is a NOP/deselect: no constraints, no state change.
  - L L L (MRS) issues after the tRFC counter only.
  - Bank index b = instr[ROW_OFFSET +: BANK_WIDTH].
- Issue conditions (all counters must be 0):
  - ACT: act_cnt[b] and rrd_cnt.
  - RD/WR: rcd_cnt[b].
  - PRE: pre_cnt[b].
  - REF: all act_cnt.
  - Every non-NOP command also requires rfc_cnt.
- issue = hold_valid && conditions met.
- Outputs are registered, with exactly 1 cycle from issue to dec_en:
  - dec_en(t+1) = issue(t); dec_instr(t+1) = hold(t).
  - Minimum latency from accept to dec_en is 2 cycles.
- Handshake:
  - in_ready = !hold_valid || issue, which is combinational from registered state.
  - On accept, hold loads in_instr. Accept and issue in the same cycle is allowed, giving back-to-back throughput of 1 per cycle when unconstrained.
- Counters: each counter decrements by 1 per cycle and saturates at 0. On issue, the listed counters load in place of decrementing:
  - ACT b: rcd_cnt[b] = T_RCD-1; pre_cnt[b] = max(pre_cnt[b], T_RAS-1); rrd_cnt = T_RRD-1.
  - PRE b: act_cnt[b] = T_RP-1.
  - RD b: pre_cnt[b] = max(pre_cnt[b]-1, T_RTP-1).
  - WR b: pre_cnt[b] = max(pre_cnt[b]-1, T_WTP-1).
  - REF: rfc_cnt = T_RFC-1.
- Resulting timing: a command issued at cycle n lets the dependent command issue no earlier than cycle n + T_x. All T_x must be at least 1.
- Bank state: ACT sets open[b]; PRE clears open[b]; REF leaves state unchanged.
- Errors:
  - Checked at issue. A violating instruction still issues.
  - err is set; err_code is captured only on the first error and holds until rst.
- stall_cycles increments when hold_valid && !issue, and saturates at 16'hFFFF.

Test Plan:
- Reset, then ACT b2, then RD b2 presented immediately: ACT dec_en at cycle 2; RD dec_en exactly 4 cycles later; stall_cycles = 3; in_ready low during the stall.
- ACT b0 then ACT b1 back-to-back: second dec_en exactly T_RRD = 2 cycles after the first; err = 0.
- ACT b3, WR b3, PRE b3, ACT b3: PRE issues at max(ACT+10, WR+8); the final ACT issues 4 cycles after PRE.
- REF then NOP then ACT b0: NOP issues the next cycle; ACT issues 40 cycles after REF.
- RD b5 with b5 closed: RD issues; err = 1, err_code = 2. A later ACT to an open bank leaves err_code = 2.
- 20 unconstrained NOPs with in_valid held high: dec_en high for 20 consecutive cycles; stall_cycles = 0. rst asserted mid-stream: dec_en = 0 the next cycle and the held instruction is dropped.
